cmpt_result_serializer: RTL
===========================

Name: cmpt_result_serializer

Overview:
- Drains one Pendulum Compute result frame per step and returns it to the host side as a stream of per-PE records.
- Captures the wide parallel obs/rwd/done vectors when Compute pulses o_valid, then emits one beat per PE (PE 0 first) over a valid/ready stream.
- Sits between Compute's result outputs and the host/DMA egress; it is the outbound counterpart of the state/action feed into Compute.

Parameters:
- PE_NUM, 40, number of parallel environments / records per frame
- OBS_WL, 96, per-PE observation width {th_dot, sinth, costh}, FP32 each
- RWD_WL, 32, per-PE reward width, FP32
- IDX_WL, 6, PE index width; must satisfy 2**IDX_WL >= PE_NUM

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  synchronous active-low reset
- i_valid  in  1  Compute o_valid; one-cycle frame strobe
- i_obs  in  PE_NUM*OBS_WL  Compute o_obs; PE g at [g*OBS_WL +: OBS_WL]
- i_rwd  in  PE_NUM*RWD_WL  Compute o_rwd
- i_done  in  PE_NUM  Compute o_done
- o_cap_rdy  out  1  high in IDLE; frame strobe is accepted only when high
- o_data  out  OBS_WL+RWD_WL+1  beat = {done, rwd, th_dot, sinth, costh}
- o_idx  out  IDX_WL  PE index of current beat
- o_hdr  out  1  current beat is a header beat
- o_last  out  1  final beat of frame
- o_valid  out  1  beat valid
- i_ready  in  1  downstream accepts beat
- o_ovf  out  1  sticky: a frame strobe arrived while busy

Behaviour:
- Reset (i_rstn low at posedge): state IDLE; o_valid, o_last, o_hdr, o_ovf = 0; o_idx = 0; o_data = 0; capture register cleared. Any frame in flight is discarded with no partial beats afterwards.
- States: IDLE, HDR (macro only), SEND.
- IDLE: o_cap_rdy = 1. On i_valid, latch i_obs/i_rwd/i_done into the capture register. Next state is SEND (or HDR). o_valid rises the cycle after the strobe (latency 1).
- SEND:
  - o_data = {cap_done[idx], cap_rwd[idx], cap_obs[idx]}; o_idx = idx.
  - Beat transfers on o_valid && i_ready.
  - On transfer, idx increments; at idx == PE_NUM-1, o_last = 1, and the transfer returns to IDLE with idx = 0.
- Backpressure: while o_valid && !i_ready, o_data/o_idx/o_last/o_hdr hold stable and o_valid stays high.
- o_valid is never deasserted mid-frame without a transfer.
- Busy strobe: i_valid while state != IDLE is ignored (capture register untouched) and sets o_ovf = 1 until reset.
- Final beat accepted in the same cycle as i_valid: the strobe is an overflow, since o_cap_rdy is 0 that cycle. Back-to-back frames need at least one IDLE cycle.
- Payload passes through bit-exact; no arithmetic on the FP32 fields.
- PE_NUM = 1: a single beat carries o_last = 1.

Optional Feature:
- Macro: CMPT_RESULT_SERIALIZER_HDR_EN.
- Defined:
  - After capture, go to HDR and emit one header beat before PE 0, with o_hdr = 1, o_idx = 0, o_last = 0.
  - Header o_data = {zero pad, done_cnt[15:0], frame_cnt[31:0]}.
  - frame_cnt counts captured frames, starting at 0 after reset, wrapping at 2^32; it increments when the header transfers.
  - done_cnt is the popcount of captured i_done.
  - Frame is PE_NUM+1 beats.
- Undefined: no HDR state; o_hdr is tied 0; frame is PE_NUM beats.

Test Plan:
- Reset, then i_valid with PE0 obs = {32'hc04c5ab1, 32'hbecb1234, 32'hbf6b0000}, rwd = 32'hc0ef0e2a, done = 0; i_ready = 1 -> o_valid rises the cycle after the strobe. Beat 0 o_data = {0, c0ef0e2a, c04c5ab1, becb1234, bf6b0000}, o_idx = 0. 40 consecutive beats follow; o_last only at o_idx = 39; then o_cap_rdy = 1.
- i_ready toggled 1010… across the frame -> every beat appears exactly once, in order 0..39, and holds stable while stalled; frame takes 79 cycles.
- Second i_valid at o_idx = 10 with different data -> o_ovf = 1 and stays set; remaining beats 11..39 carry first-frame data.
- Assert reset when o_idx = 20 -> o_valid = 0 the next cycle, o_ovf clears; a new frame afterwards starts at o_idx = 0.
- i_valid on the cycle the last beat transfers -> o_ovf = 1 and no new frame; i_valid one cycle later -> accepted, o_ovf stays 1.
- HDR_EN, two frames with i_done = 40'h00000000F1 -> header 1 = {done_cnt = 5, frame_cnt = 0}, header 2 = {done_cnt = 5, frame_cnt = 1}; each frame is 41 beats; o_hdr is high only on the header beat.

Source files
------------

// File: rtl/cmpt_result_serializer_if.sv
// Outbound per-PE record stream of the Compute result serializer.
// valid/ready beat with PE index, header and end-of-frame flags.
interface cmpt_result_serializer_if #(
  parameter int DATA_WL = 129,
  parameter int IDX_WL  = 6
);
  logic [DATA_WL-1:0] data;
  logic [IDX_WL-1:0]  idx;
  logic               hdr;
  logic               last;
  logic               valid;
  logic               ready;

  modport master (
    output data, idx, hdr, last, valid,
    input  ready
  );

  modport slave (
    input  data, idx, hdr, last, valid,
    output ready
  );
endinterface

// File: rtl/cmpt_result_serializer.sv
// Captures one Compute result frame and streams it out one PE per beat.
// CMPT_RESULT_SERIALIZER_HDR_EN adds a header beat (done count, frame count).
module cmpt_result_serializer #(
  parameter int PE_NUM = 40,
  parameter int OBS_WL = 96,
  parameter int RWD_WL = 32,
  parameter int IDX_WL = 6
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic                     i_valid,
  input  logic [PE_NUM*OBS_WL-1:0] i_obs,
  input  logic [PE_NUM*RWD_WL-1:0] i_rwd,
  input  logic [PE_NUM-1:0]        i_done,
  output logic                     o_cap_rdy,
  output logic                     o_ovf,
  cmpt_result_serializer_if.master m
);

  localparam int DATA_WL = OBS_WL + RWD_WL + 1;
  localparam logic [IDX_WL-1:0] LAST_IDX = IDX_WL'(PE_NUM - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1
`ifdef CMPT_RESULT_SERIALIZER_HDR_EN
    , S_HDR = 2'd2
`endif
  } state_t;

  state_t state;
  state_t state_nx;

  logic [PE_NUM*OBS_WL-1:0] cap_obs;
  logic [PE_NUM*RWD_WL-1:0] cap_rwd;
  logic [PE_NUM-1:0]        cap_done;
  logic [IDX_WL-1:0]        idx;
  logic                     ovf;

  logic               ready;
  logic               is_last;
  logic               busy;
  logic [DATA_WL-1:0] data_c;
  logic [IDX_WL-1:0]  idx_c;
  logic               hdr_c;
  logic               last_c;
  logic               valid_c;
  logic               cap_rdy_c;

  assign ready   = m.ready;
  assign is_last = (idx == LAST_IDX);
  assign busy    = (state != S_IDLE);

`ifdef CMPT_RESULT_SERIALIZER_HDR_EN
  logic [31:0] frame_cnt;
  logic [15:0] done_cnt;
  logic [15:0] done_pop;

  always_comb begin
    done_pop = '0;
    for (int g = 0; g < PE_NUM; g++) begin
      done_pop = done_pop + 16'(i_done[g]);
    end
  end
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (i_valid) begin
`ifdef CMPT_RESULT_SERIALIZER_HDR_EN
          state_nx = S_HDR;
`else
          state_nx = S_SEND;
`endif
        end
      end
`ifdef CMPT_RESULT_SERIALIZER_HDR_EN
      S_HDR: begin
        if (ready) state_nx = S_SEND;
      end
`endif
      S_SEND: begin
        if (ready && is_last) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    cap_rdy_c = 1'b0;
    valid_c   = 1'b0;
    hdr_c     = 1'b0;
    last_c    = 1'b0;
    idx_c     = '0;
    data_c    = '0;
    unique case (state)
      S_IDLE: cap_rdy_c = 1'b1;
`ifdef CMPT_RESULT_SERIALIZER_HDR_EN
      S_HDR: begin
        valid_c = 1'b1;
        hdr_c   = 1'b1;
        data_c  = {{(DATA_WL-48){1'b0}}, done_cnt, frame_cnt};
      end
`endif
      S_SEND: begin
        valid_c = 1'b1;
        last_c  = is_last;
        idx_c   = idx;
        data_c  = {cap_done[idx],
                   cap_rwd[int'(idx)*RWD_WL +: RWD_WL],
                   cap_obs[int'(idx)*OBS_WL +: OBS_WL]};
      end
      default: cap_rdy_c = 1'b0;
    endcase
  end

  // A strobe is only taken in IDLE; anything else is a lost frame.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      cap_obs  <= '0;
      cap_rwd  <= '0;
      cap_done <= '0;
      idx      <= '0;
      ovf      <= 1'b0;
`ifdef CMPT_RESULT_SERIALIZER_HDR_EN
      frame_cnt <= '0;
      done_cnt  <= '0;
`endif
    end else begin
      if (i_valid && !busy) begin
        cap_obs  <= i_obs;
        cap_rwd  <= i_rwd;
        cap_done <= i_done;
`ifdef CMPT_RESULT_SERIALIZER_HDR_EN
        done_cnt <= done_pop;
`endif
      end
      if (i_valid && busy) begin
        ovf <= 1'b1;
      end
      if (state == S_SEND && ready) begin
        idx <= is_last ? '0 : idx + 1'b1;
      end
`ifdef CMPT_RESULT_SERIALIZER_HDR_EN
      if (state == S_HDR && ready) begin
        frame_cnt <= frame_cnt + 32'd1;
      end
`endif
    end
  end

  assign o_cap_rdy = cap_rdy_c;
  assign o_ovf     = ovf;
  assign m.data    = data_c;
  assign m.idx     = idx_c;
  assign m.hdr     = hdr_c;
  assign m.last    = last_c;
  assign m.valid   = valid_c;

endmodule
